// File: rtl/decl_pkg.sv
// Shared definitions for the declaration emitter and the intcheck recognizer:
// FSM state encoding, buffer entry layout and the fixed ASCII characters of the stream.
package decl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KW0,
        KW1,
        KW2,
        SP,
        ID,
        COMMA,
        SEMI
    } state_e;

    // One buffered identifier character plus its end-of-identifier flag.
    typedef struct packed {
        logic       last;
        logic [7:0] ch;
    } entry_t;

    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_T     = 8'h74;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SEMI  = 8'h3B;

endpackage

// File: rtl/int_decl_emitter_if.sv
// Load port and character stream of the declaration emitter.
// The master modport is the emitter itself; the slave side loads identifiers and consumes the stream.
interface int_decl_emitter_if;

    logic       wr_en;
    logic [7:0] wr_char;
    logic       wr_end;
    logic       wr_full;
    logic       go;
    logic       busy;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       done;
    logic       err;

    modport master (
        input  wr_en, wr_char, wr_end, go, out_ready,
        output wr_full, busy, out, out_valid, done, err
    );

    modport slave (
        output wr_en, wr_char, wr_end, go, out_ready,
        input  wr_full, busy, out, out_valid, done, err
    );

endinterface

// File: rtl/decl_char_fifo.sv
// Single-clock FIFO holding {end, char} identifier entries; head is the oldest entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module decl_char_fifo
    import decl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  entry_t      push_data_i,
    input  logic        pop_i,
    output entry_t      head_o,
    output logic [AW:0] count_o,
    output logic        full_o
);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/int_decl_emitter.sv
// Serializes the buffered identifiers as "int id0,id1,...;" one ASCII char per transfer.
// The FSM output mux selects keyword/punctuation constants or the FIFO head.
module int_decl_emitter
    import decl_pkg::*;
#(
    parameter int BUF_DEPTH = 16,
    parameter int PTR_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    int_decl_emitter_if.master  bus
);

    state_e         state_q;
    state_e         state_d;
    logic           done_q;
    logic           done_d;
    logic           err_q;
    logic           err_d;
    logic [7:0]     ch;
    logic           pop;
    logic           idle;
    logic           xfer;
    logic           push_ok;
    logic           fifo_full;
    logic [PTR_W:0] count;
    entry_t         head;

    assign idle = (state_q == IDLE);
    assign xfer = ~idle & bus.out_ready;
    // A push coinciding with go is dropped so the emitted list matches the buffer at go.
    assign push_ok = bus.wr_en & idle & ~bus.go;

    decl_char_fifo #(
        .DEPTH (BUF_DEPTH),
        .AW    (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_ok),
        .push_data_i ('{last: bus.wr_end, ch: bus.wr_char}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        ch      = 8'h00;
        pop     = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    if (count != '0) state_d = KW0;
                    else             err_d   = 1'b1;
                end
            end
            KW0: begin
                ch = CH_I;
                if (xfer) state_d = KW1;
            end
            KW1: begin
                ch = CH_N;
                if (xfer) state_d = KW2;
            end
            KW2: begin
                ch = CH_T;
                if (xfer) state_d = SP;
            end
            SP: begin
                ch = CH_SP;
                if (xfer) state_d = ID;
            end
            ID: begin
                // The last buffered char closes the list even without its end flag.
                ch = head.ch;
                if (xfer) begin
                    pop = 1'b1;
                    if (count == (PTR_W+1)'(1)) state_d = SEMI;
                    else if (head.last)         state_d = COMMA;
                    else                        state_d = ID;
                end
            end
            COMMA: begin
                ch = CH_COMMA;
                if (xfer) state_d = ID;
            end
            SEMI: begin
                ch = CH_SEMI;
                if (xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.out       = ch;
    assign bus.out_valid = ~idle;
    assign bus.busy      = ~idle;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.wr_full   = ~idle | fifo_full;

endmodule

// File: tb/tb_int_decl_emitter.sv
// Self-checking bench for int_decl_emitter: table of declarations plus hand-written
// sequences for full buffer, empty go and reset mid-emission; a scoreboard checks the stream.
module tb_int_decl_emitter;
    import decl_pkg::*;

    typedef struct {
        string name;
        string idList;
        bit    stall;
        bit    injectBusy;
        string expected;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    int_decl_emitter_if bus();

    int_decl_emitter #(
        .BUF_DEPTH (16),
        .PTR_W     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;
    int xferCount   = 0;
    int firstXferCycle = 0;
    int lastXferCycle  = 0;
    int doneCount   = 0;
    int doneCycle   = 0;
    byte unsigned sbQ[$];
    vec_t vecs[4];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every valid cycle must show the char at the head of the queue,
    // including stall cycles, and a transfer retires it.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.done === 1'b1) begin
                doneCount++;
                doneCycle = cycle;
            end
            if (bus.out_valid === 1'b1) begin
                if (sbQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedChar: got %0h, expected no valid char", bus.out);
                end else begin
                    checkOutput("outChar", {24'h0, bus.out}, {24'h0, sbQ[0]});
                    if (bus.out_ready === 1'b1) begin
                        void'(sbQ.pop_front());
                        if (xferCount == 0) firstXferCycle = cycle;
                        lastXferCycle = cycle;
                        xferCount++;
                    end
                end
            end
        end
    end

    task automatic pushChar(input byte c, input bit e);
        bus.wr_en   = 1'b1;
        bus.wr_char = c;
        bus.wr_end  = e;
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
    endtask

    // '|' after a char marks it as the last char of its identifier.
    task automatic loadIds(input string idList);
        for (int i = 0; i < idList.len(); i++) begin
            if (idList[i] != "|") begin
                pushChar(idList[i], (i + 1 < idList.len()) && (idList[i+1] == "|"));
            end
        end
    endtask

    task automatic runEmission(input string expected, input bit stall, input bit injectBusy);
        int prevDone;
        int g;
        int k;
        for (int i = 0; i < expected.len(); i++) sbQ.push_back(expected[i]);
        xferCount     = 0;
        prevDone      = doneCount;
        bus.out_ready = 1'b1;
        bus.go        = 1'b1;
        g = cycle;
        @(posedge clk); #1;
        bus.go = 1'b0;
        k = 0;
        while (doneCount == prevDone && k < 200) begin
            if (injectBusy && k == 0) begin
                checkOutput("wrFullWhileBusy", bus.wr_full, 1);
                bus.wr_en   = 1'b1;
                bus.wr_char = "z";
                bus.wr_end  = 1'b1;
                bus.go      = 1'b1;
            end else begin
                bus.wr_en = 1'b0;
                bus.go    = 1'b0;
            end
            if (stall) bus.out_ready = ~bus.out_ready;
            @(posedge clk); #1;
            k++;
        end
        bus.wr_en     = 1'b0;
        bus.go        = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("doneSeen", doneCount - prevDone, 1);
        checkOutput("sbEmpty", sbQ.size(), 0);
        checkOutput("xferCount", xferCount, expected.len());
        checkOutput("doneLatency", doneCycle, lastXferCycle + 1);
        checkOutput("donePulseWidth", bus.done, 0);
        checkOutput("busyAfterDone", bus.busy, 0);
        checkOutput("validAfterDone", bus.out_valid, 0);
        if (!stall) begin
            checkOutput("firstCharLatency", firstXferCycle, g + 1);
            checkOutput("noBubbles", lastXferCycle, g + expected.len());
        end
        sbQ.delete();
    endtask

    task automatic checkErr(input string tag);
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        checkOutput({tag, "_err"}, bus.err, 1);
        checkOutput({tag, "_validIdle"}, bus.out_valid, 0);
        checkOutput({tag, "_busyIdle"}, bus.busy, 0);
        @(posedge clk); #1;
        checkOutput({tag, "_errPulse"}, bus.err, 0);
        checkOutput({tag, "_stillIdle"}, bus.busy, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_out"}, bus.out, 8'h00);
        checkOutput({tag, "_outValid"}, bus.out_valid, 0);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_done"}, bus.done, 0);
        checkOutput({tag, "_err"}, bus.err, 0);
        checkOutput({tag, "_wrFull"}, bus.wr_full, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        loadIds(v.idList);
        runEmission(v.expected, v.stall, v.injectBusy);
    endtask

    initial begin
        int k;
        int prevDone;
        vecs[0] = '{name: "twoIds",    idList: "a|b|",   stall: 1'b0, injectBusy: 1'b0, expected: "int a,b;"};
        vecs[1] = '{name: "stallIds",  idList: "ab|x|",  stall: 1'b1, injectBusy: 1'b0, expected: "int ab,x;"};
        vecs[2] = '{name: "noEndFlag", idList: "c",      stall: 1'b0, injectBusy: 1'b1, expected: "int c;"};
        vecs[3] = '{name: "threeIds",  idList: "x|yz|w|", stall: 1'b1, injectBusy: 1'b0, expected: "int x,yz,w;"};

        reset         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_char   = 8'h00;
        bus.wr_end    = 1'b0;
        bus.go        = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        checkErr("emptyGo");

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %s", vecs[i].name);
            applyStimulus(vecs[i]);
        end
        checkErr("consumed");

        // Overfill: the 17th push must be dropped.
        for (int i = 0; i < 17; i++) begin
            pushChar(8'h61 + i[7:0], (i == 7) || (i == 16));
            if (i == 14) checkOutput("notFullAt15", bus.wr_full, 0);
            if (i == 15) checkOutput("fullAt16", bus.wr_full, 1);
        end
        checkOutput("fullAfter17", bus.wr_full, 1);
        runEmission("int abcdefgh,ijklmnop;", 1'b0, 1'b0);
        checkErr("afterFull");

        // Reset while the comma is on the bus abandons the declaration.
        loadIds("a|b|");
        sbQ.push_back("i"); sbQ.push_back("n"); sbQ.push_back("t");
        sbQ.push_back(" "); sbQ.push_back("a"); sbQ.push_back(",");
        bus.out_ready = 1'b1;
        bus.go        = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        k = 0;
        while (bus.out !== CH_COMMA && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        bus.out_ready = 1'b0;
        checkOutput("reachComma", bus.out, CH_COMMA);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkResetOutputs("midReset");
        sbQ.delete();
        @(posedge clk); #3;
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        prevDone = doneCount;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("noDoneAfterReset", doneCount - prevDone, 0);
        checkResetOutputs("released");
        checkErr("afterReset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
